// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
//   Front-end and result stage wrapped around the 64-bit iterative divider.
//   It decodes the RV64M divide ops, prepares and holds the divider operands,
//   fires a single-cycle request, waits for the result, selects quotient or
//   remainder, sign-extends W results, and presents the result to writeback
//   behind a valid/ready handshake.
//
//   Optional feature macro: DIV_FAST_PATH_EN
//     When defined, divide-by-zero and signed overflow are resolved at accept
//     time without involving the divider (IDLE -> RESP directly).
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   flush           kills any in-flight op, mirrored to the divider
//   in_valid/ready  op handshake from EXU (in_op, in_rs1, in_rs2, in_tag)
//                   in_op: bit0 = rem, bit1 = unsigned, bit2 = word
//   div_*           request/response interface of the iterative divider
//   out_valid/ready result handshake to writeback (out_data, out_tag)

module div_issue_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [63:0]      in_rs1,
  input  logic [63:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_flush,
  output logic             div_signed,
  output logic             div_valid,
  output logic [63:0]      div_dividend,
  output logic [63:0]      div_divisor,
  input  logic [63:0]      div_quotient,
  input  logic [63:0]      div_remainder,
  input  logic             div_o_valid,
  output logic             div_o_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Only the result-side decode needs to survive past accept; the
  // signedness is already folded into div_signed and the operands.
  typedef struct packed {
    logic word;
    logic rem;
  } op_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic [TAG_W-1:0] tag_q;
  logic [63:0]      dvd_q, dvs_q;
  logic             sgn_q;

  logic [63:0]      dvd_prep, dvs_prep;
  logic             accept;
  logic             take_res;
  logic [63:0]      sel;
  logic             fast_hit;
  logic [63:0]      fast_res;

  // W results are the low 32 bits sign-extended; 64-bit results pass through.
  function automatic logic [63:0] fmt_res(input logic word, input logic [63:0] v);
    fmt_res = word ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  // ---------------------------------------------------------------------
  // Operand preparation
  // ---------------------------------------------------------------------
  always_comb begin
    dvd_prep = in_rs1;
    dvs_prep = in_rs2;
    if (in_op[2]) begin
      if (in_op[1]) begin
        dvd_prep = {32'b0, in_rs1[31:0]};
        dvs_prep = {32'b0, in_rs2[31:0]};
      end else begin
        dvd_prep = {{32{in_rs1[31]}}, in_rs1[31:0]};
        dvs_prep = {{32{in_rs2[31]}}, in_rs2[31:0]};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Fast path: the two corner cases whose answer is known from the operands
  // ---------------------------------------------------------------------
`ifdef DIV_FAST_PATH_EN
  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    if (dvs_prep == 64'd0) begin
      fast_hit = 1'b1;
      fast_res = in_op[0] ? dvd_prep : '1;
    end else if (!in_op[1] && dvd_prep == 64'h8000_0000_0000_0000 && dvs_prep == '1) begin
      fast_hit = 1'b1;
      fast_res = in_op[0] ? 64'd0 : dvd_prep;
    end
  end
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  assign accept    = (state == IDLE) && in_valid && !flush;
  assign take_res  = (state == WAIT) && div_o_valid && !flush;
  assign div_flush = flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    div_valid   = 1'b0;
    div_o_ready = 1'b0;
    out_valid   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = fast_hit ? RESP : ISSUE;
      end
      ISSUE: begin
        // One-cycle pulse: a held request would restart the divider.
        div_valid = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        div_o_ready = 1'b1;
        if (div_o_valid) state_nxt = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        // Return to IDLE, not straight to accept: costs one bubble between ops.
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Flush overrides everything, including an accept in the same cycle.
    if (flush) state_nxt = IDLE;
  end

  // ---------------------------------------------------------------------
  // Operand / op / tag hold registers. The divider samples these live, so
  // they are only written at accept.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q <= '0;
      dvs_q <= '0;
      sgn_q <= 1'b0;
      op_q  <= '0;
      tag_q <= '0;
    end else if (accept) begin
      dvd_q <= dvd_prep;
      dvs_q <= dvs_prep;
      sgn_q <= ~in_op[1];
      op_q  <= '{word: in_op[2], rem: in_op[0]};
      tag_q <= in_tag;
    end
  end

  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign div_signed   = sgn_q;

  // ---------------------------------------------------------------------
  // Result register: loaded from the divider in WAIT, or from the fast path
  // at accept. Untouched while in RESP, so it is stable under backpressure.
  // ---------------------------------------------------------------------
  assign sel = op_q.rem ? div_remainder : div_quotient;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_tag  <= '0;
    end else if (accept && fast_hit) begin
      out_data <= fmt_res(in_op[2], fast_res);
      out_tag  <= in_tag;
    end else if (take_res) begin
      out_data <= fmt_res(op_q.word, sel);
      out_tag  <= tag_q;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl. The bench plays the divider: it captures
// the request, computes RV64 divide semantics, and answers after a chosen
// number of cycles. Expected results are hand-computed constants.
module tb_div_issue_ctrl;
  localparam int TAG_W = 5;
`ifdef DIV_FAST_PATH_EN
  localparam int CORNER_REQ = 0;
`else
  localparam int CORNER_REQ = 1;
`endif

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready;
  logic [2:0]       in_op;
  logic [63:0]      in_rs1, in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             div_flush, div_signed, div_valid, div_o_valid, div_o_ready;
  logic [63:0]      div_dividend, div_divisor, div_quotient, div_remainder;
  logic             out_valid, out_ready;
  logic [63:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  int n_cmp = 0;
  int n_err = 0;
  int last_req, last_lat;
  logic [63:0] cap_dvd, cap_dvs;
  logic        cap_sgn;

  always #5 clk = ~clk;

  div_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .div_flush(div_flush), .div_signed(div_signed), .div_valid(div_valid),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_o_valid(div_o_valid), .div_o_ready(div_o_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference divider (RV64 semantics, incl. /0 and overflow).
  task automatic divide(input logic sg, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] q, output logic [63:0] r);
    if (b == 64'd0) begin
      q = '1; r = a;
    end else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a; r = 64'd0;
    end else if (sg) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Issue one op, act as the divider with latency lat, check the result,
  // hold writeback off for 'hold' cycles, then complete the handshake.
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] tag, input int lat, input int hold,
                        input int exp_req, input logic [63:0] exp, input string name);
    logic [63:0] q, r;
    bit pend, got;
    int cnt;
    pend = 0; got = 0; cnt = 0; q = '0; r = '0;
    last_req = 0; last_lat = -1;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (div_o_valid) begin div_o_valid = 1'b0; pend = 0; end
      if (out_valid) begin got = 1; last_lat = c; break; end
      if (div_valid) begin
        last_req++;
        pend = 1; cnt = lat - 1;
        cap_dvd = div_dividend; cap_dvs = div_divisor; cap_sgn = div_signed;
        divide(div_signed, div_dividend, div_divisor, q, r);
      end else if (pend) begin
        if (cnt <= 0) begin
          div_o_valid = 1'b1; div_quotient = q; div_remainder = r;
        end else cnt--;
      end
      @(negedge clk);
    end
    chk({name, " done"}, 64'(got), 64'd1);
    chk({name, " data"}, out_data, exp);
    chk({name, " tag"}, 64'(out_tag), 64'(tag));
    chk({name, " reqs"}, 64'(last_req), 64'(exp_req));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk({name, " hold valid"}, 64'(out_valid), 64'd1);
      chk({name, " hold data"}, out_data, exp);
      chk({name, " hold tag"}, 64'(out_tag), 64'(tag));
      chk({name, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " idle in_ready"}, 64'(in_ready), 64'd1);
    chk({name, " idle out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_rs1 = '0; in_rs2 = '0; in_tag = '0;
    div_quotient = '0; div_remainder = '0; div_o_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst div_valid", 64'(div_valid), 64'd0);
    chk("rst div_o_ready", 64'(div_o_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", out_data, 64'd0);
    chk("rst out_tag", 64'(out_tag), 64'd0);
    chk("rst dividend", div_dividend, 64'd0);
    chk("rst signed", 64'(div_signed), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Signed 64-bit divide / remainder
    run_op(3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD, "div -7/2");
    run_op(3'b001, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, 3, 5, 1, 64'hFFFF_FFFF_FFFF_FFFF, "rem -7/2");

    // Word unsigned divide by zero
    run_op(3'b110, 64'h1_8000_0000, 64'd0, 5'd3, 2, 0, CORNER_REQ, 64'hFFFF_FFFF_FFFF_FFFF, "divuw /0");
`ifndef DIV_FAST_PATH_EN
    chk("divuw dividend", cap_dvd, 64'h0000_0000_8000_0000);
    chk("divuw divisor", cap_dvs, 64'd0);
    chk("divuw signed", 64'(cap_sgn), 64'd0);
`endif
    run_op(3'b111, 64'h1_8000_0000, 64'd0, 5'd4, 1, 0, CORNER_REQ, 64'hFFFF_FFFF_8000_0000, "remuw /0");

    // Word signed "overflow" (not an overflow in 64-bit, goes to the divider)
    run_op(3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 5'd5, 1, 0, 1, 64'hFFFF_FFFF_8000_0000, "divw ovf");
    chk("divw dividend", cap_dvd, 64'hFFFF_FFFF_8000_0000);
    chk("divw divisor", cap_dvs, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("divw signed", 64'(cap_sgn), 64'd1);

    // 64-bit signed overflow
    run_op(3'b000, 64'h8000_0000_0000_0000, '1, 5'd6, 1, 0, CORNER_REQ, 64'h8000_0000_0000_0000, "div ovf");
`ifdef DIV_FAST_PATH_EN
    chk("div ovf fast latency", 64'(last_lat), 64'd0);
`endif
    run_op(3'b001, 64'h8000_0000_0000_0000, '1, 5'd7, 1, 0, CORNER_REQ, 64'd0, "rem ovf");

    // Flush deep into WAIT; operands must stay put while EXU inputs churn
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b000; in_rs1 = 64'h1234; in_rs2 = 64'd5; in_tag = 5'd11;
    @(negedge clk);
    in_valid = 1'b0;
    chk("flush issue pulse", 64'(div_valid), 64'd1);
    @(negedge clk);
    chk("flush wait no req", 64'(div_valid), 64'd0);
    in_valid = 1'b1; in_rs1 = '1; in_rs2 = '1;
    repeat (10) @(negedge clk);
    chk("flush held dividend", div_dividend, 64'h1234);
    chk("flush held divisor", div_divisor, 64'd5);
    chk("flush wait o_ready", 64'(div_o_ready), 64'd1);
    flush = 1'b1;
    #1 chk("flush div_flush on", 64'(div_flush), 64'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush div_flush off", 64'(div_flush), 64'd0);
    chk("flush back idle", 64'(in_ready), 64'd1);
    chk("flush no out_valid", 64'(out_valid), 64'd0);
    chk("flush no o_ready", 64'(div_o_ready), 64'd0);

    // Flush in IDLE with a simultaneous request: request dropped
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b010; in_rs1 = 64'd9; in_rs2 = 64'd3; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("idle flush no accept", 64'(in_ready), 64'd1);
    chk("idle flush no req", 64'(div_valid), 64'd0);

    run_op(3'b010, 64'd100, 64'd7, 5'd9, 2, 0, 1, 64'd14, "divu 100/7");

    // Async reset mid-WAIT
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'b000; in_rs1 = 64'h50; in_rs2 = 64'd3; in_tag = 5'd13;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst wait o_ready", 64'(div_o_ready), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst in_ready", 64'(in_ready), 64'd1);
    chk("arst o_ready", 64'(div_o_ready), 64'd0);
    chk("arst out_data", out_data, 64'd0);
    chk("arst out_tag", 64'(out_tag), 64'd0);
    chk("arst dividend", div_dividend, 64'd0);
    chk("arst divisor", div_divisor, 64'd0);
    chk("arst signed", 64'(div_signed), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fast-path candidate after reset (divider path in the default build)
    run_op(3'b000, 64'd5, 64'd0, 5'd17, 1, 0, CORNER_REQ, 64'hFFFF_FFFF_FFFF_FFFF, "div 5/0");
`ifdef DIV_FAST_PATH_EN
    chk("div 5/0 fast latency", 64'(last_lat), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Front-end and result stage for the 64-bit iterative divider: sits between the EXU dispatch and writeback, and wraps the divider on both sides.
- Decodes the eight RV64M divide ops (DIV/DIVU/REM/REMU and the W forms).
- Prepares and holds the divider operands, issues a single-cycle request, and waits for the divider result.
- Selects quotient or remainder, sign-extends W results, and buffers the result behind a valid/ready handshake to writeback.

Parameters:
TAG_W, 5, width of the destination tag (rd index) carried alongside the op.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
flush  input  1  pipeline flush; kills any in-flight op
in_valid  input  1  op request from EXU
in_ready  output  1  block can accept an op
in_op  input  3  bit0=rem(1)/div(0), bit1=unsigned, bit2=word
in_rs1  input  64  dividend source
in_rs2  input  64  divisor source
in_tag  input  TAG_W  destination tag
div_flush  output  1  flush to divider
div_signed  output  1  signed request to divider
div_valid  output  1  request to divider
div_dividend  output  64  dividend to divider
div_divisor  output  64  divisor to divider
div_quotient  input  64  divider quotient
div_remainder  input  64  divider remainder
div_o_valid  input  1  divider result valid
div_o_ready  output  1  result accepted from divider
out_valid  output  1  result to writeback valid
out_ready  input  1  writeback accepts
out_data  output  64  final result
out_tag  output  TAG_W  tag of result

Behaviour:
- Reset: state=IDLE; in_ready=1; every other output is 0 (div_valid, div_o_ready, div_flush, out_valid, out_data, out_tag, operand registers).
- Only clk is used. rst acts asynchronously on every register.
- Operand preparation at accept:
  - Word signed: dividend = sext(rs1[31:0]), divisor = sext(rs2[31:0]).
  - Word unsigned: both operands zero-extended from bit 31.
  - Non-word: operands pass unmodified.
  - div_signed = ~in_op[1].
- The operand registers, div_signed, op and tag stay constant from accept until the op leaves RESP or is flushed. The divider samples its inputs live, so they must not change mid-divide.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - in_ready=1.
  - in_valid & ~flush: latch operands/op/tag, go to ISSUE.
- ISSUE:
  - div_valid=1 for exactly one cycle, then go to WAIT.
  - div_valid must never be held longer than one cycle; a held request restarts the divider.
- WAIT:
  - div_o_ready=1.
  - On div_o_valid: select div_remainder if op.rem, else div_quotient.
  - If op.word, out_data = sext(sel[31:0]); otherwise out_data = sel.
  - Register out_data and out_tag, go to RESP.
- RESP:
  - out_valid=1; out_data/out_tag stable while out_valid & ~out_ready.
  - On out_ready: go to IDLE.
  - A new op is not accepted in the same cycle as the response handoff; back-to-back ops therefore have 1 idle cycle.
- Latency: accept edge to out_valid = 2 cycles + divider latency (divider latency is 1 cycle when the divider reuses its cached last result).
- Divide-by-zero and signed overflow are resolved by the divider; the W forms come out correct through the sign-extension above.
- flush, in any state:
  - div_flush=flush, combinationally.
  - Next state is IDLE; out_valid is cleared next cycle.
  - in_valid in the same cycle is not accepted, since flush has priority.
  - flush during ISSUE still drives div_valid that cycle; the divider gives its flush priority, so the request is dropped.

Optional Feature:
DIV_FAST_PATH_EN:
- Defined: in IDLE at accept, the divider is bypassed for two cases, computed from the prepared operands:
  - Divisor==0: quotient=all ones, rem=dividend.
  - Signed and dividend==0x8000_0000_0000_0000 and divisor==all ones: quotient=dividend, rem=0.
  - The W-form sext rule applies to the bypass result.
  - The result is loaded directly and state goes IDLE->RESP, so out_valid is asserted 1 cycle after accept.
  - div_valid is never asserted for these ops.
- Not defined: all ops take the ISSUE/WAIT path.

Test Plan:
- DIV rs1=-7 (0xFFFF_FFFF_FFFF_FFF9), rs2=2 -> out_data=0xFFFF_FFFF_FFFF_FFFD; REM on the same operands -> 0xFFFF_FFFF_FFFF_FFFF; div_valid high exactly one cycle per op.
- DIVUW rs1=0x1_8000_0000, rs2=0 -> out_data=0xFFFF_FFFF_FFFF_FFFF; REMUW on the same operands -> 0xFFFF_FFFF_8000_0000.
- DIVW rs1=0x8000_0000, rs2=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000; DIV rs1=0x8000_0000_0000_0000, rs2=-1 -> 0x8000_0000_0000_0000, REM -> 0.
- Hold out_ready=0 for 5 cycles in RESP -> out_valid, out_data and out_tag stable, in_ready=0; release -> IDLE next cycle, in_ready=1.
- Assert flush 10 cycles into WAIT -> div_flush pulses, state returns to IDLE, no out_valid; the next op (DIVU 100/7) returns 14 with the correct tag.
- Assert rst mid-WAIT -> all outputs 0 immediately. With DIV_FAST_PATH_EN: DIV x/0 gives out_valid 1 cycle after accept and div_valid never asserted.
